// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: op codes, register-file constants
// and small op classification helpers used by the FSM and the lane logic.
package mem_access_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [REG_AW-1:0] ZERO_REG = '0;
   localparam logic [XLEN-1:0]   ZERO     = '0;

   typedef enum logic [3:0] {
      MEM_NOP = 4'd0,
      MEM_LB  = 4'd1,
      MEM_LH  = 4'd2,
      MEM_LW  = 4'd3,
      MEM_LBU = 4'd4,
      MEM_LHU = 4'd5,
      MEM_SB  = 4'd6,
      MEM_SH  = 4'd7,
      MEM_SW  = 4'd8
   } mem_op_e;

   function automatic logic op_is_load(mem_op_e op);
      return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
   endfunction

   function automatic logic op_is_store(mem_op_e op);
      return op inside {MEM_SB, MEM_SH, MEM_SW};
   endfunction

   // Halfword accesses need an even address, word accesses a 4-byte aligned one.
   function automatic logic op_misaligned(mem_op_e op, logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if (op inside {MEM_LH, MEM_LHU, MEM_SH}) mis = off[0];
      if (op inside {MEM_LW, MEM_SW})          mis = (off != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_lane.sv
// Byte-lane datapath: byte enables and lane-replicated store data for the
// outgoing request, plus load extraction with sign/zero extension on return.
// Half accesses select on off_i[1] only, word accesses ignore off_i.
module mem_access_lane
   import mem_access_pkg::*;
(
   input  mem_op_e          op_i,
   input  logic [1:0]       off_i,
   input  logic [XLEN-1:0]  sdata_i,
   input  logic [XLEN-1:0]  rdata_i,
   output logic [3:0]       be_o,
   output logic [XLEN-1:0]  wdata_o,
   output logic [XLEN-1:0]  ldata_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = 8'(rdata_i >> {off_i, 3'b000});
   assign half_v = 16'(rdata_i >> {off_i[1], 4'b0000});

   // Request side: which lanes the access touches and the replicated store data.
   always_comb begin
      be_o    = 4'b0000;
      wdata_o = ZERO;
      case (op_i)
         MEM_LB, MEM_LBU, MEM_SB: be_o = 4'b0001 << off_i;
         MEM_LH, MEM_LHU, MEM_SH: be_o = off_i[1] ? 4'b1100 : 4'b0011;
         MEM_LW, MEM_SW:          be_o = 4'b1111;
         default:                 be_o = 4'b0000;
      endcase
      case (op_i)
         MEM_SB:  wdata_o = {4{sdata_i[7:0]}};
         MEM_SH:  wdata_o = {2{sdata_i[15:0]}};
         MEM_SW:  wdata_o = sdata_i;
         default: wdata_o = ZERO;
      endcase
   end

   // Response side: pick the addressed lane and extend it to a full word.
   always_comb begin
      ldata_o = ZERO;
      case (op_i)
         MEM_LB:  ldata_o = {{24{byte_v[7]}}, byte_v};
         MEM_LBU: ldata_o = {24'h0, byte_v};
         MEM_LH:  ldata_o = {{16{half_v[15]}}, half_v};
         MEM_LHU: ldata_o = {16'h0, half_v};
         MEM_LW:  ldata_o = rdata_i;
         default: ldata_o = ZERO;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory stage: passes ALU results through to write-back, runs loads/stores
// over a req/gnt/rvalid bus with an optional response timeout, and stalls
// upstream while a transaction is in flight.
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned
// half/word accesses with a misalign_o pulse instead of issuing them.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
)(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [REG_AW-1:0] reg_waddr_i,
   input  logic              reg_we_i,
   input  logic [XLEN-1:0]   reg_wdata_i,
   input  logic [XLEN-1:0]   mem_addr_i,
   input  logic [XLEN-1:0]   mem_data_i,
   input  logic              mem_we_i,
   input  logic [3:0]        mem_op_i,
   output logic              stall_o,
   output logic [REG_AW-1:0] wb_waddr_o,
   output logic              wb_we_o,
   output logic [XLEN-1:0]   wb_wdata_o,
   output logic              dbus_req_o,
   output logic              dbus_we_o,
   output logic [XLEN-1:0]   dbus_addr_o,
   output logic [XLEN-1:0]   dbus_wdata_o,
   output logic [3:0]        dbus_be_o,
   input  logic              dbus_gnt_i,
   input  logic              dbus_rvalid_i,
   input  logic [XLEN-1:0]   dbus_rdata_i,
   output logic              bus_err_o,
   output logic              misalign_o
);

   // A zero timeout still needs a legal counter width; the counter is unused then.
   localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

   state_e            state_q;
   mem_op_e           op_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   data_q;
   logic [REG_AW-1:0] waddr_q;
   logic              we_q;
   logic [TO_W-1:0]   cnt_q;
   logic [TO_W-1:0]   cnt_d;
   logic              to_hit;

   logic              wb_we_q;
   logic [REG_AW-1:0] wb_waddr_q;
   logic [XLEN-1:0]   wb_wdata_q;
   logic              bus_err_q;
   logic              misalign_q;

   mem_op_e           in_op;
   logic              in_is_mem;
   logic              in_misalign;
   logic [XLEN-1:0]   ldata;

   assign in_op     = mem_op_e'(mem_op_i);
   // Unknown op codes behave like MEM_NOP rather than launching a bogus access.
   assign in_is_mem = op_is_load(in_op) || op_is_store(in_op);

`ifdef MEM_MISALIGN_CHECK_EN
   assign in_misalign = op_misaligned(in_op, mem_addr_i[1:0]);
`else
   assign in_misalign = 1'b0;
`endif

   assign cnt_d  = cnt_q + TO_W'(1);
   assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == TO_W'(TIMEOUT_CYCLES));

   mem_access_lane u_lane (
      .op_i    (op_q),
      .off_i   (addr_q[1:0]),
      .sdata_i (data_q),
      .rdata_i (dbus_rdata_i),
      .be_o    (dbus_be_o),
      .wdata_o (dbus_wdata_o),
      .ldata_o (ldata)
   );

   // Stage FSM: pass-through in IDLE, request in REQ, wait for rvalid in RESP.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         op_q       <= MEM_NOP;
         addr_q     <= '0;
         data_q     <= '0;
         waddr_q    <= '0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         wb_we_q    <= 1'b0;
         wb_waddr_q <= '0;
         wb_wdata_q <= '0;
         bus_err_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         bus_err_q  <= 1'b0;
         misalign_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!in_is_mem) begin
                  wb_waddr_q <= reg_waddr_i;
                  wb_wdata_q <= reg_wdata_i;
                  wb_we_q    <= reg_we_i && (reg_waddr_i != ZERO_REG);
               end else if (in_misalign) begin
                  wb_we_q    <= 1'b0;
                  misalign_q <= 1'b1;
               end else begin
                  op_q    <= in_op;
                  addr_q  <= mem_addr_i;
                  data_q  <= mem_data_i;
                  waddr_q <= reg_waddr_i;
                  // A bus write needs both the store op and the store strobe.
                  we_q    <= mem_we_i && op_is_store(in_op);
                  wb_we_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (dbus_gnt_i) begin
                  cnt_q <= '0;
                  // Same-cycle rvalid completes as if it arrived after gnt.
                  if (dbus_rvalid_i) begin
                     wb_we_q    <= op_is_load(op_q) && (waddr_q != ZERO_REG);
                     wb_waddr_q <= op_is_load(op_q) ? waddr_q : wb_waddr_q;
                     wb_wdata_q <= op_is_load(op_q) ? ldata   : wb_wdata_q;
                     op_q       <= MEM_NOP;
                     we_q       <= 1'b0;
                     state_q    <= S_IDLE;
                  end else begin
                     state_q <= S_RESP;
                  end
               end else if (to_hit) begin
                  bus_err_q <= 1'b1;
                  wb_we_q   <= 1'b0;
                  op_q      <= MEM_NOP;
                  we_q      <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_RESP: begin
               if (dbus_rvalid_i) begin
                  wb_we_q    <= op_is_load(op_q) && (waddr_q != ZERO_REG);
                  wb_waddr_q <= op_is_load(op_q) ? waddr_q : wb_waddr_q;
                  wb_wdata_q <= op_is_load(op_q) ? ldata   : wb_wdata_q;
                  op_q       <= MEM_NOP;
                  we_q       <= 1'b0;
                  state_q    <= S_IDLE;
               end else if (to_hit) begin
                  bus_err_q <= 1'b1;
                  wb_we_q   <= 1'b0;
                  op_q      <= MEM_NOP;
                  we_q      <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stall_o     = (state_q != S_IDLE);
   assign dbus_req_o  = (state_q == S_REQ);
   assign dbus_we_o   = we_q;
   assign dbus_addr_o = {addr_q[XLEN-1:2], 2'b00};
   assign wb_we_o     = wb_we_q;
   assign wb_waddr_o  = wb_waddr_q;
   assign wb_wdata_o  = wb_wdata_q;
   assign bus_err_o   = bus_err_q;
   assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized loads and
// stores, checked against a byte-level reference model.
module tb_mem_access;

   localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                          OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                          OP_SW = 4'd8;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  reg_waddr = '0;
   logic        reg_we = 1'b0;
   logic [31:0] reg_wdata = '0;
   logic [31:0] mem_addr = '0, mem_data = '0;
   logic        mem_we = 1'b0;
   logic [3:0]  mem_op = '0;
   logic        gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] rdata = '0;

   logic        stall, wb_we, req, bwe, berr, mis;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata, baddr, bwdata;
   logic [3:0]  be;

   logic        t_stall, t_wb_we, t_req, t_bwe, t_berr, t_mis;
   logic [4:0]  t_wb_waddr;
   logic [31:0] t_wb_wdata, t_baddr, t_bwdata;
   logic [3:0]  t_be;

   int nchk = 0, nerr = 0;

   always #5 clk = ~clk;

   mem_access dut (
      .clk_i(clk), .rst_n_i(rst_n), .reg_waddr_i(reg_waddr), .reg_we_i(reg_we),
      .reg_wdata_i(reg_wdata), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
      .mem_we_i(mem_we), .mem_op_i(mem_op), .stall_o(stall), .wb_waddr_o(wb_waddr),
      .wb_we_o(wb_we), .wb_wdata_o(wb_wdata), .dbus_req_o(req), .dbus_we_o(bwe),
      .dbus_addr_o(baddr), .dbus_wdata_o(bwdata), .dbus_be_o(be), .dbus_gnt_i(gnt),
      .dbus_rvalid_i(rvalid), .dbus_rdata_i(rdata), .bus_err_o(berr), .misalign_o(mis)
   );

   mem_access #(.TIMEOUT_CYCLES(TO)) dut_to (
      .clk_i(clk), .rst_n_i(rst_n), .reg_waddr_i(reg_waddr), .reg_we_i(reg_we),
      .reg_wdata_i(reg_wdata), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
      .mem_we_i(mem_we), .mem_op_i(mem_op), .stall_o(t_stall), .wb_waddr_o(t_wb_waddr),
      .wb_we_o(t_wb_we), .wb_wdata_o(t_wb_wdata), .dbus_req_o(t_req), .dbus_we_o(t_bwe),
      .dbus_addr_o(t_baddr), .dbus_wdata_o(t_bwdata), .dbus_be_o(t_be), .dbus_gnt_i(gnt),
      .dbus_rvalid_i(rvalid), .dbus_rdata_i(rdata), .bus_err_o(t_berr), .misalign_o(t_mis)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_st(logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic [3:0] ref_be(logic [3:0] op, logic [31:0] a);
      int o = int'(a % 4);
      case (op)
         OP_SB:   return 4'(1 << o);
         OP_SH:   return (o >= 2) ? 4'hC : 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(logic [3:0] op, logic [31:0] d);
      case (op)
         OP_SB:   return 32'(d[7:0])  * 32'h0101_0101;
         OP_SH:   return 32'(d[15:0]) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(logic [3:0] op, logic [31:0] a, logic [31:0] rd);
      int o = int'(a % 4);
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      int v;
      sb = rd[8*o +: 8];
      sh = (o >= 2) ? rd[31:16] : rd[15:0];
      case (op)
         OP_LB:   begin v = sb; return v; end
         OP_LH:   begin v = sh; return v; end
         OP_LBU:  return {24'h0, sb};
         OP_LHU:  return {16'h0, sh};
         default: return rd;
      endcase
   endfunction

   // One complete access on the main instance: gd idle cycles before gnt,
   // rvalid rvd cycles after gnt (0 = same cycle as gnt).
   task automatic do_mem(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd,
                         input logic [31:0] rdat, input int gd, input int rvd);
      mem_op = op; mem_addr = a; mem_data = d; mem_we = is_st(op);
      reg_waddr = rd; reg_we = !is_st(op); reg_wdata = $urandom;
      step();
      mem_op = OP_NOP; mem_we = 1'b0; reg_we = 1'b0;
      for (int i = 0; i <= gd; i++) begin
         chk({tag, "_req"},   32'(req),   32'd1);
         chk({tag, "_stall"}, 32'(stall), 32'd1);
         chk({tag, "_wbwe0"}, 32'(wb_we), 32'd0);
         chk({tag, "_addr"},  baddr,      a & ~32'd3);
         chk({tag, "_we"},    32'(bwe),   32'(is_st(op)));
         if (is_st(op)) begin
            chk({tag, "_be"},    32'(be), 32'(ref_be(op, a)));
            chk({tag, "_wdata"}, bwdata,  ref_wdata(op, d));
         end
         if (i == gd) begin
            gnt = 1'b1;
            if (rvd == 0) begin rvalid = 1'b1; rdata = rdat; end
         end
         step();
      end
      gnt = 1'b0; rvalid = 1'b0; rdata = $urandom;
      for (int i = 1; i <= rvd; i++) begin
         chk({tag, "_rstall"}, 32'(stall), 32'd1);
         chk({tag, "_rreq0"},  32'(req),   32'd0);
         chk({tag, "_rwbwe0"}, 32'(wb_we), 32'd0);
         if (i == rvd) begin rvalid = 1'b1; rdata = rdat; end
         step();
      end
      rvalid = 1'b0; rdata = $urandom;
      chk({tag, "_done_stall"}, 32'(stall), 32'd0);
      chk({tag, "_wbwe"}, 32'(wb_we), 32'(!is_st(op) && rd != 0));
      if (!is_st(op) && rd != 0) begin
         chk({tag, "_wbaddr"}, 32'(wb_waddr), 32'(rd));
         chk({tag, "_wbdata"}, wb_wdata, ref_load(op, a, rdat));
      end
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a, d, r;
      logic [4:0]  rd;

      // Reset state
      #3;
      chk("rst_stall", 32'(stall), 0); chk("rst_req", 32'(req), 0);
      chk("rst_wbwe", 32'(wb_we), 0);  chk("rst_wbdata", wb_wdata, 0);
      chk("rst_be", 32'(be), 0);       chk("rst_berr", 32'(berr), 0);
      chk("rst_to_stall", 32'(t_stall), 0);
      step(); step();
      rst_n = 1'b1;

      // ALU pass-through, including x0 suppression
      for (int i = 0; i < 10; i++) begin
         rd = (i % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         reg_waddr = rd; reg_we = 1'($urandom); reg_wdata = $urandom;
         d = reg_wdata;
         step();
         chk("nop_wbwe",  32'(wb_we), 32'(reg_we && rd != 0));
         chk("nop_waddr", 32'(wb_waddr), 32'(rd));
         chk("nop_wdata", wb_wdata, d);
         chk("nop_stall", 32'(stall), 0);
         chk("nop_req",   32'(req), 0);
      end
      reg_we = 1'b0;

      // Directed accesses
      do_mem("sw",  OP_SW,  32'h100, 32'hDEADBEEF, 5'd0, 32'h0, 0, 1);
      do_mem("lb",  OP_LB,  32'h203, 32'h0,        5'd5, 32'h80FF_0000, 0, 1);
      chk("lb_const", wb_wdata, 32'hFFFF_FF80);
      do_mem("lbu", OP_LBU, 32'h203, 32'h0,        5'd5, 32'h80FF_0000, 1, 2);
      chk("lbu_const", wb_wdata, 32'h0000_0080);
      do_mem("sh",  OP_SH,  32'h42,  32'h1234,     5'd0, 32'h0, 5, 1);

      // ALU op held in execute behind an LW: written exactly once, one cycle later
      mem_op = OP_LW; mem_addr = 32'h80; mem_we = 1'b0; reg_waddr = 5'd9; reg_we = 1'b1;
      step();
      mem_op = OP_NOP; reg_waddr = 5'd3; reg_we = 1'b1; reg_wdata = 32'd7;
      chk("add_hold_wbwe0", 32'(wb_we), 0);
      gnt = 1'b1; step(); gnt = 1'b0;
      chk("add_hold_wbwe1", 32'(wb_we), 0);
      rvalid = 1'b1; rdata = 32'hCAFE_F00D; step(); rvalid = 1'b0;
      chk("lw_wbwe",   32'(wb_we), 1); chk("lw_waddr", 32'(wb_waddr), 9);
      chk("lw_wdata",  wb_wdata, 32'hCAFE_F00D);
      step();
      reg_we = 1'b0;
      chk("add_wbwe", 32'(wb_we), 1); chk("add_waddr", 32'(wb_waddr), 3);
      chk("add_wdata", wb_wdata, 32'd7);
      step();
      chk("add_once", 32'(wb_we), 0);

      // Timeout on the short-timeout instance (resynchronise both first)
      rst_n = 1'b0; #1; rst_n = 1'b1;
      mem_op = OP_SW; mem_addr = 32'h300; mem_data = 32'h55; mem_we = 1'b1;
      step();
      mem_op = OP_NOP; mem_we = 1'b0;
      for (int i = 0; i < TO; i++) begin
         chk("to_req_held", 32'(t_req), 1);
         chk("to_no_err",   32'(t_berr), 0);
         step();
      end
      chk("to_berr",  32'(t_berr), 1);  chk("to_req0", 32'(t_req), 0);
      chk("to_stall", 32'(t_stall), 0); chk("to_wbwe", 32'(t_wb_we), 0);
      step();
      chk("to_berr_pulse", 32'(t_berr), 0);
      chk("to_main_waiting", 32'(req), 1);
      gnt = 1'b1; rvalid = 1'b1; step(); gnt = 1'b0; rvalid = 1'b0;
      chk("to_main_done", 32'(stall), 0);
      chk("to_gnt_ignored", 32'(t_req), 0);
      chk("to_rv_ignored",  32'(t_wb_we), 0);

      // Reset during RESP: immediate abort, late rvalid ignored
      mem_op = OP_LW; mem_addr = 32'h400; reg_waddr = 5'd5; step();
      mem_op = OP_NOP; gnt = 1'b1; step(); gnt = 1'b0;
      chk("mid_stall", 32'(stall), 1);
      rst_n = 1'b0; #1;
      chk("mid_rst_stall", 32'(stall), 0); chk("mid_rst_req", 32'(req), 0);
      chk("mid_rst_wbwe", 32'(wb_we), 0);  chk("mid_rst_addr", baddr, 0);
      chk("mid_rst_be", 32'(be), 0);       chk("mid_rst_we", 32'(bwe), 0);
      step(); rst_n = 1'b1;
      rvalid = 1'b1; rdata = 32'h1111_2222; step(); rvalid = 1'b0;
      chk("late_rv_wbwe", 32'(wb_we), 0); chk("late_rv_stall", 32'(stall), 0);
      chk("late_rv_req", 32'(req), 0);

      // Misaligned word access
`ifdef MEM_MISALIGN_CHECK_EN
      mem_op = OP_LW; mem_addr = 32'h102; reg_waddr = 5'd6; step();
      mem_op = OP_NOP;
      chk("mis_pulse", 32'(mis), 1);  chk("mis_req", 32'(req), 0);
      chk("mis_stall", 32'(stall), 0); chk("mis_wbwe", 32'(wb_we), 0);
      step();
      chk("mis_pulse_end", 32'(mis), 0);
`else
      do_mem("lw_mis", OP_LW, 32'h102, 32'h0, 5'd6, 32'h0BAD_F00D, 0, 1);
      chk("mis_tied0", 32'(mis), 0);
`endif

      // Randomized accesses
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(1, 8));
         a  = $urandom; d = $urandom; r = $urandom;
         rd = 5'($urandom_range(0, 31));
`ifdef MEM_MISALIGN_CHECK_EN
         if (op == OP_LH || op == OP_LHU || op == OP_SH) a[0] = 1'b0;
         if (op == OP_LW || op == OP_SW) a[1:0] = 2'b00;
`endif
         do_mem("rnd", op, a, d, rd, r, $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
